// File: rtl/alu_wide_seq.sv
// Multi-cycle wide ALU controller: runs NBYTES-wide operations through an external
// 8-bit ALU one byte per cycle, LSB first, chaining carry and aggregating flags.
module alu_wide_seq #(
    parameter int unsigned NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] res_data,
    output logic                res_c,
    output logic                res_n,
    output logic                res_v,
    output logic                res_z,
    output logic                alu_s2,
    output logic                alu_s1,
    output logic                alu_s0,
    output logic                alu_cin,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    input  logic [7:0]          alu_op,
    input  logic                alu_c,
    input  logic                alu_n,
    input  logic                alu_v,
    input  logic                alu_z
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned KW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic            z_acc_q, z_acc_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic            res_c_q, res_c_d, res_n_q, res_n_d;
    logic            res_v_q, res_v_d, res_z_q, res_z_d;
    logic            res_valid_q, res_valid_d;

    logic [W-1:0]    a_sh, b_sh;
    logic            last_byte;

    assign a_sh      = a_q >> {k_q, 3'b000};
    assign b_sh      = b_q >> {k_q, 3'b000};
    assign last_byte = (k_q == KW'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            z_acc_q     <= 1'b0;
            res_data_q  <= '0;
            res_c_q     <= 1'b0;
            res_n_q     <= 1'b0;
            res_v_q     <= 1'b0;
            res_z_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            z_acc_q     <= z_acc_d;
            res_data_q  <= res_data_d;
            res_c_q     <= res_c_d;
            res_n_q     <= res_n_d;
            res_v_q     <= res_v_d;
            res_z_q     <= res_z_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        carry_d     = carry_q;
        z_acc_d     = z_acc_q;
        res_data_d  = res_data_q;
        res_c_d     = res_c_q;
        res_n_d     = res_n_q;
        res_v_d     = res_v_q;
        res_z_d     = res_z_q;
        res_valid_d = res_valid_q;
        req_ready   = 1'b0;
        alu_s2      = 1'b0;
        alu_s1      = 1'b0;
        alu_s0      = 1'b0;
        alu_cin     = 1'b0;
        alu_a       = 8'h00;
        alu_b       = 8'h00;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d       = req_op;
                    a_d        = req_a;
                    b_d        = req_b;
                    res_data_d = '0;
                    z_acc_d    = 1'b1;
                    k_d        = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                alu_s2 = op_q[3];
                alu_s1 = op_q[2];
                alu_s0 = op_q[1];
                // Logic ops use cin as a function select, so it must not follow the carry chain.
                alu_cin = (op_q[3] || k_q == '0) ? op_q[0] : carry_q;
                alu_a   = a_sh[7:0];
                alu_b   = b_sh[7:0];
                for (int i = 0; i < NBYTES; i++) begin
                    if (k_q == KW'(i)) res_data_d[8*i +: 8] = alu_op;
                end
                carry_d = alu_c;
                z_acc_d = z_acc_q & alu_z;
                k_d     = k_q + 1'b1;
                if (last_byte) begin
                    res_n_d     = alu_n;
                    res_z_d     = z_acc_q & alu_z;
                    res_c_d     = ~op_q[3] & alu_c;
                    res_v_d     = ~op_q[3] & alu_v;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_c     = res_c_q;
    assign res_n     = res_n_q;
    assign res_v     = res_v_q;
    assign res_z     = res_z_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq (NBYTES=2) with a behavioural 8-bit ALU attached.
`define CHK(tag, obs, exp) \
    begin \
        nvec++; \
        assert ((obs) === (exp)) else begin \
            nmis++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_alu_wide_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        res_c, res_n, res_v, res_z;
    logic        alu_s2, alu_s1, alu_s0, alu_cin;
    logic [7:0]  alu_a, alu_b, alu_op;
    logic        alu_c, alu_n, alu_v, alu_z;

    int nvec = 0;
    int nmis = 0;
    int lat;
    logic [1:0] cins;

    always #5 clk = ~clk;

    alu_wide_seq #(.NBYTES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_c(res_c), .res_n(res_n), .res_v(res_v), .res_z(res_z),
        .alu_s2(alu_s2), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_cin(alu_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z)
    );

    // 8-bit ALU: arithmetic A + {0, B, ~B, FF} + cin; logic selected by {s1,s0,cin}.
    logic [7:0] bop;
    logic [8:0] sum9;
    always_comb begin
        bop    = 8'h00;
        sum9   = 9'h000;
        alu_op = 8'h00;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case ({alu_s1, alu_s0})
            2'b00: bop = 8'h00;
            2'b01: bop = alu_b;
            2'b10: bop = ~alu_b;
            default: bop = 8'hFF;
        endcase
        if (!alu_s2) begin
            sum9   = {1'b0, alu_a} + {1'b0, bop} + {8'h00, alu_cin};
            alu_op = sum9[7:0];
            alu_c  = sum9[8];
            alu_v  = (alu_a[7] == bop[7]) && (sum9[7] != alu_a[7]);
        end else begin
            case ({alu_s1, alu_s0, alu_cin})
                3'b000: alu_op = alu_a & alu_b;
                3'b001: alu_op = alu_a | alu_b;
                3'b010: alu_op = alu_a ^ alu_b;
                3'b011: alu_op = ~alu_a;
                3'b100: alu_op = alu_a;
                3'b101: alu_op = alu_b;
                3'b110: alu_op = ~(alu_a | alu_b);
                default: alu_op = ~(alu_a & alu_b);
            endcase
        end
        alu_n = alu_op[7];
        alu_z = (alu_op == 8'h00);
    end

    // Accept one request, then wait (bounded) for res_valid; records alu_cin per byte cycle.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        `CHK("req_ready_before_accept", req_ready, 1'b1)
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
        req_op    = ~op;
        lat  = 0;
        cins = 2'b00;
        while (!res_valid && lat < 10) begin
            if (lat < 2) cins[lat] = alu_cin;
            @(posedge clk);
            #1;
            lat++;
        end
        nvec++;
        if (!res_valid) begin
            nmis++;
            $error("FAIL run_op_timeout: res_valid not seen within %0d cycles", lat);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] data,
                             input logic c, input logic n, input logic v, input logic z);
        `CHK(tag, {res_valid, res_data, res_c, res_n, res_v, res_z}, {1'b1, data, c, n, v, z})
    endtask

    task automatic handoff();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        `CHK("handoff_valid", res_valid, 1'b0)
        `CHK("handoff_ready", req_ready, 1'b1)
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        res_ready = 1'b0;
        #12;
        nvec++;
        if ({res_valid, res_data, res_c, res_n, res_v, res_z} !== 21'h0) begin
            nmis++;
            $error("FAIL reset_state: outputs %0h not zero",
                   {res_valid, res_data, res_c, res_n, res_v, res_z});
        end
        `CHK("reset_alu", {alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}, 20'h0)
        `CHK("reset_ready", req_ready, 1'b1)
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 00FF + 0001: carry ripples into byte 1
        run_op(4'b0010, 16'h00FF, 16'h0001);
        `CHK("add_latency", lat, 2)
        `CHK("add_cin_bytes", cins, 2'b10)
        check_res("add_res", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        handoff();

        run_op(4'b0101, 16'h1234, 16'h1234);
        check_res("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        handoff();

        run_op(4'b0101, 16'h0000, 16'h0001);
        check_res("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        handoff();

        run_op(4'b0001, 16'hFFFF, 16'h0000);
        check_res("inc_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        handoff();

        run_op(4'b1010, 16'hF0F0, 16'hFFFF);
        `CHK("xor_cin_bytes", cins, 2'b00)
        check_res("xor_res", 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        handoff();

        run_op(4'b1011, 16'h00FF, 16'h1234);
        `CHK("not_latency", lat, 2)
        check_res("not_res", 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0);
        handoff();

        // Backpressure: result must hold while a new request is waiting
        run_op(4'b0010, 16'h0003, 16'h0004);
        @(negedge clk);
        req_op    = 4'b0010;
        req_a     = 16'h0010;
        req_b     = 16'h0020;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_res("bp_hold", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
            `CHK("bp_not_ready", req_ready, 1'b0)
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        `CHK("bp_release_valid", res_valid, 1'b0)
        `CHK("bp_release_ready", req_ready, 1'b1)
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        `CHK("bp_accepted", req_ready, 1'b0)
        lat = 0;
        while (!res_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nvec++;
        if (!res_valid) begin
            nmis++;
            $error("FAIL bp_wait_timeout: res_valid not seen within %0d cycles", lat);
        end
        `CHK("bp_new_latency", lat, 2)
        check_res("bp_new_res", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        handoff();

        // Asynchronous reset during the byte-1 cycle of an ADD
        @(negedge clk);
        req_op    = 4'b0010;
        req_a     = 16'h00FF;
        req_b     = 16'h0001;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        `CHK("pre_reset_cin", alu_cin, 1'b1)
        rst_n = 1'b0;
        #1;
        `CHK("abort_valid", res_valid, 1'b0)
        `CHK("abort_ready", req_ready, 1'b1)
        `CHK("abort_alu", {alu_s2, alu_s1, alu_s0, alu_cin, alu_a, alu_b}, 20'h0)
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        `CHK("post_reset_ready", req_ready, 1'b1)
        run_op(4'b0010, 16'h0001, 16'h0001);
        `CHK("post_reset_latency", lat, 2)
        check_res("post_reset_add", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        handoff();

        if (nmis != 0) $error("SUMMARY: %0d miscompares out of %0d vectors", nmis, nvec);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
